// File: rtl/smt_pkg.sv
// Shared types and constants for stream_max_tracker.
// State encoding and compare-mode selectors.
package smt_pkg;

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  localparam bit CMP_UNSIGNED = 1'b0;
  localparam bit CMP_SIGNED   = 1'b1;

endpackage

// File: rtl/cmp_gt_n.sv
// Combinational a > b, unsigned or two's-complement.
// Signed mode flips both MSBs and reuses the unsigned compare.
module cmp_gt_n
  import smt_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter bit SIGNED = CMP_UNSIGNED
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             gt
);

  logic [WIDTH-1:0] ak;
  logic [WIDTH-1:0] bk;

  // Bias operands so signed order maps onto unsigned order
  always_comb begin
    ak = a;
    bk = b;
    if (SIGNED == CMP_SIGNED) begin
      ak[WIDTH-1] = ~a[WIDTH-1];
      bk[WIDTH-1] = ~b[WIDTH-1];
    end
    gt = (ak > bk);
  end

endmodule

// File: rtl/stream_max_tracker.sv
// Frame-wise running max (and optional min) tracker.
// Optional min tracking is enabled by defining TRACK_MIN_EN.
module stream_max_tracker
  import smt_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int FRAME_LEN = 16,
  parameter bit SIGNED    = CMP_UNSIGNED,
  localparam int IDX_W    = $clog2(FRAME_LEN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_max,
  output logic [IDX_W-1:0] out_idx
`ifdef TRACK_MIN_EN
  ,
  output logic [WIDTH-1:0] out_min,
  output logic [IDX_W-1:0] out_min_idx
`endif
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(FRAME_LEN - 1);

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] count;
  logic [WIDTH-1:0] max_q;
  logic [IDX_W-1:0] idx_q;
  logic             take;
  logic             last;
  logic             first;
  logic             gt_max;

  assign take  = in_valid && in_ready && !clr;
  assign last  = (count == LAST);
  assign first = (count == '0);

  cmp_gt_n #(
    .WIDTH (WIDTH),
    .SIGNED(SIGNED)
  ) u_cmp_max (
    .a (in_data),
    .b (max_q),
    .gt(gt_max)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_ACC;
    else        state <= state_nxt;
  end

  // Next-state: clr wins, otherwise frame end / result handshake
  always_comb begin
    state_nxt = state;
    if (clr) begin
      state_nxt = ST_ACC;
    end else begin
      unique case (state)
        ST_ACC:  if (take && last) state_nxt = ST_HOLD;
        ST_HOLD: if (out_ready)    state_nxt = ST_ACC;
        default: state_nxt = ST_ACC;
      endcase
    end
  end

  // Handshake outputs decoded from registered state
  always_comb begin
    in_ready  = (state == ST_ACC);
    out_valid = (state == ST_HOLD);
  end

  // Element position within the current frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    count <= '0;
    else if (clr)  count <= '0;
    else if (take) count <= last ? '0 : count + 1'b1;
  end

  // Running max; strict compare keeps the earliest tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_q <= '0;
      idx_q <= '0;
    end else if (take && (first || gt_max)) begin
      max_q <= in_data;
      idx_q <= count;
    end
  end

  assign out_max = max_q;
  assign out_idx = idx_q;

`ifdef TRACK_MIN_EN
  logic [WIDTH-1:0] min_q;
  logic [IDX_W-1:0] min_idx_q;
  logic             lt_min;

  cmp_gt_n #(
    .WIDTH (WIDTH),
    .SIGNED(SIGNED)
  ) u_cmp_min (
    .a (min_q),
    .b (in_data),
    .gt(lt_min)
  );

  // Running min; mirrors the max rules
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_q     <= '0;
      min_idx_q <= '0;
    end else if (take && (first || lt_min)) begin
      min_q     <= in_data;
      min_idx_q <= count;
    end
  end

  assign out_min     = min_q;
  assign out_min_idx = min_idx_q;
`endif

endmodule
